// File: rtl/ifu2idu_skid.sv
// Fetch-to-decode pipeline boundary: a 2-entry skid buffer carrying {pc, inst}.
// The upstream ready is decoded from state only, and an EXU redirect flushes every held beat.
module ifu2idu_skid #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_rst_n,
   input  logic                  i_ifu_valid,
   output logic                  o_ifu_ready,
   input  logic [ADDR_WIDTH-1:0] i_ifu_pc,
   input  logic [DATA_WIDTH-1:0] i_ifu_inst,
   output logic                  o_idu_valid,
   input  logic                  i_idu_ready,
   output logic [ADDR_WIDTH-1:0] o_idu_pc,
   output logic [DATA_WIDTH-1:0] o_idu_inst,
   input  logic                  i_exu_jmp_en
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]            state_r;
   logic [1:0]            state_nxt_s;
   logic [ADDR_WIDTH-1:0] main_pc_r;
   logic [DATA_WIDTH-1:0] main_inst_r;
   logic [ADDR_WIDTH-1:0] skid_pc_r;
   logic [DATA_WIDTH-1:0] skid_inst_r;
   logic                  acc_s;
   logic                  pop_s;
   logic                  load_main_in_s;
   logic                  load_main_skid_s;
   logic                  load_skid_s;

   assign acc_s = i_ifu_valid & o_ifu_ready;
   assign pop_s = o_idu_valid & i_idu_ready;

   // State register.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         state_r <= ST_EMPTY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and load selection; a flush overrides every handshake.
   always_comb begin
      state_nxt_s      = state_r;
      load_main_in_s   = 1'b0;
      load_main_skid_s = 1'b0;
      load_skid_s      = 1'b0;
      if (i_exu_jmp_en) begin
         state_nxt_s = ST_EMPTY;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (acc_s) begin
                  state_nxt_s    = ST_ONE;
                  load_main_in_s = 1'b1;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (acc_s && !pop_s) begin
                  state_nxt_s = ST_TWO;
                  load_skid_s = 1'b1;
               end else if (acc_s && pop_s) begin
                  state_nxt_s    = ST_ONE;
                  load_main_in_s = 1'b1;
               end else if (pop_s) begin
                  state_nxt_s = ST_EMPTY;
               end else begin
                  state_nxt_s = ST_ONE;
               end
            end
            ST_TWO: begin
               if (pop_s) begin
                  state_nxt_s      = ST_ONE;
                  load_main_skid_s = 1'b1;
               end else begin
                  state_nxt_s = ST_TWO;
               end
            end
            default: begin
               state_nxt_s = ST_EMPTY;
            end
         endcase
      end
   end

   // Handshake outputs decoded from the state register alone.
   always_comb begin
      o_idu_valid = 1'b0;
      o_ifu_ready = 1'b1;
      case (state_r)
         ST_EMPTY: begin
            o_idu_valid = 1'b0;
            o_ifu_ready = 1'b1;
         end
         ST_ONE: begin
            o_idu_valid = 1'b1;
            o_ifu_ready = 1'b1;
         end
         ST_TWO: begin
            o_idu_valid = 1'b1;
            o_ifu_ready = 1'b0;
         end
         default: begin
            o_idu_valid = 1'b0;
            o_ifu_ready = 1'b1;
         end
      endcase
   end

   // Head and skid payload registers.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         main_pc_r   <= '0;
         main_inst_r <= '0;
         skid_pc_r   <= '0;
         skid_inst_r <= '0;
      end else begin
         if (load_main_in_s) begin
            main_pc_r   <= i_ifu_pc;
            main_inst_r <= i_ifu_inst;
         end else if (load_main_skid_s) begin
            main_pc_r   <= skid_pc_r;
            main_inst_r <= skid_inst_r;
         end
         if (load_skid_s) begin
            skid_pc_r   <= i_ifu_pc;
            skid_inst_r <= i_ifu_inst;
         end
      end
   end

   assign o_idu_pc   = main_pc_r;
   assign o_idu_inst = main_inst_r;

endmodule

// File: tb/tb_ifu2idu_skid.sv
// Directed self-checking bench for ifu2idu_skid: reset, streaming, backpressure,
// flush, flush with a simultaneous accept, and asynchronous reset while full.
module tb_ifu2idu_skid;

   logic        clk;
   logic        rst_n;
   logic        ifu_valid;
   logic        ifu_ready;
   logic [31:0] ifu_pc;
   logic [31:0] ifu_inst;
   logic        idu_valid;
   logic        idu_ready;
   logic [31:0] idu_pc;
   logic [31:0] idu_inst;
   logic        jmp_en;

   int checks = 0;
   int errors = 0;

   ifu2idu_skid #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .i_sys_clk   (clk),
      .i_sys_rst_n (rst_n),
      .i_ifu_valid (ifu_valid),
      .o_ifu_ready (ifu_ready),
      .i_ifu_pc    (ifu_pc),
      .i_ifu_inst  (ifu_inst),
      .o_idu_valid (idu_valid),
      .i_idu_ready (idu_ready),
      .o_idu_pc    (idu_pc),
      .o_idu_inst  (idu_inst),
      .i_exu_jmp_en(jmp_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [31:0] pc);
      ifu_valid = v;
      ifu_pc    = pc;
      ifu_inst  = pc ^ 32'hA5A5_0000;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; jmp_en = 1'b0; idu_ready = 1'b0;
      offer(1'b0, 32'h0);
      #1;
      checks++; if ({idu_valid, ifu_ready} !== 2'b01) begin errors++; $display("FAIL reset_hs got=%b exp=01", {idu_valid, ifu_ready}); end
      checks++; if (idu_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", idu_pc); end
      checks++; if (idu_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", idu_inst); end
      tick();
      checks++; if ({idu_valid, ifu_ready} !== 2'b01) begin errors++; $display("FAIL reset_hold got=%b exp=01", {idu_valid, ifu_ready}); end
      rst_n = 1'b1;
      tick();
      checks++; if ({idu_valid, ifu_ready} !== 2'b01) begin errors++; $display("FAIL reset_rel_hs got=%b exp=01", {idu_valid, ifu_ready}); end
      checks++; if (idu_pc !== 32'h0) begin errors++; $display("FAIL reset_rel_pc got=%h exp=0", idu_pc); end
   endtask

   task automatic test_streaming();
      logic [31:0] pc;
      idu_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pc = 32'h8000_0000 + 32'(i) * 32'd4;
         offer(1'b1, pc);
         tick();
         checks++; if (idu_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, idu_valid); end
         checks++; if (idu_pc !== pc) begin errors++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, idu_pc, pc); end
         checks++; if (idu_inst !== (pc ^ 32'hA5A5_0000)) begin errors++; $display("FAIL stream_inst[%0d] got=%h exp=%h", i, idu_inst, pc ^ 32'hA5A5_0000); end
         checks++; if (ifu_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, ifu_ready); end
      end
      offer(1'b0, 32'h0);
      tick();
      checks++; if (idu_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", idu_valid); end
   endtask

   task automatic fill_two();
      idu_ready = 1'b0;
      offer(1'b1, 32'h8000_0000);
      tick();
      offer(1'b1, 32'h8000_0004);
      tick();
      offer(1'b0, 32'h0);
   endtask

   task automatic test_backpressure();
      fill_two();
      checks++; if ({idu_valid, ifu_ready} !== 2'b10) begin errors++; $display("FAIL bp_two_hs got=%b exp=10", {idu_valid, ifu_ready}); end
      checks++; if (idu_pc !== 32'h8000_0000) begin errors++; $display("FAIL bp_head got=%h exp=80000000", idu_pc); end
      tick();
      checks++; if (idu_pc !== 32'h8000_0000) begin errors++; $display("FAIL bp_stable got=%h exp=80000000", idu_pc); end
      checks++; if (ifu_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got=%b exp=0", ifu_ready); end
      idu_ready = 1'b1;
      tick();
      checks++; if ({idu_valid, ifu_ready} !== 2'b11) begin errors++; $display("FAIL bp_pop1_hs got=%b exp=11", {idu_valid, ifu_ready}); end
      checks++; if (idu_pc !== 32'h8000_0004) begin errors++; $display("FAIL bp_pop1_pc got=%h exp=80000004", idu_pc); end
      checks++; if (idu_inst !== 32'h25A5_0004) begin errors++; $display("FAIL bp_pop1_inst got=%h exp=25a50004", idu_inst); end
      tick();
      checks++; if (idu_valid !== 1'b0) begin errors++; $display("FAIL bp_pop2_valid got=%b exp=0", idu_valid); end
   endtask

   task automatic test_flush();
      fill_two();
      jmp_en = 1'b1;
      tick();
      jmp_en = 1'b0;
      checks++; if ({idu_valid, ifu_ready} !== 2'b01) begin errors++; $display("FAIL flush_hs got=%b exp=01", {idu_valid, ifu_ready}); end
      offer(1'b1, 32'h9000_0000);
      tick();
      offer(1'b0, 32'h0);
      checks++; if (idu_valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid got=%b exp=1", idu_valid); end
      checks++; if (idu_pc !== 32'h9000_0000) begin errors++; $display("FAIL flush_next_pc got=%h exp=90000000", idu_pc); end
      idu_ready = 1'b1;
      tick();
      checks++; if (idu_valid !== 1'b0) begin errors++; $display("FAIL flush_no_stale got=%b exp=0 pc=%h", idu_valid, idu_pc); end
   endtask

   task automatic test_flush_accept();
      idu_ready = 1'b0;
      offer(1'b1, 32'h8000_0008);
      tick();
      checks++; if (idu_pc !== 32'h8000_0008) begin errors++; $display("FAIL fa_one_pc got=%h exp=80000008", idu_pc); end
      offer(1'b1, 32'h8000_0010);
      jmp_en = 1'b1;
      tick();
      jmp_en = 1'b0;
      offer(1'b0, 32'h0);
      checks++; if ({idu_valid, ifu_ready} !== 2'b01) begin errors++; $display("FAIL fa_empty_hs got=%b exp=01", {idu_valid, ifu_ready}); end
      tick();
      checks++; if (idu_valid !== 1'b0) begin errors++; $display("FAIL fa_never got=%b exp=0 pc=%h", idu_valid, idu_pc); end
   endtask

   task automatic test_async_reset();
      fill_two();
      checks++; if (ifu_ready !== 1'b0) begin errors++; $display("FAIL ar_two got=%b exp=0", ifu_ready); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({idu_valid, ifu_ready} !== 2'b01) begin errors++; $display("FAIL ar_hs got=%b exp=01", {idu_valid, ifu_ready}); end
      checks++; if (idu_pc !== 32'h0) begin errors++; $display("FAIL ar_pc got=%h exp=0", idu_pc); end
      checks++; if (idu_inst !== 32'h0) begin errors++; $display("FAIL ar_inst got=%h exp=0", idu_inst); end
      #2 rst_n = 1'b1;
      idu_ready = 1'b1;
      tick();
      checks++; if (idu_valid !== 1'b0) begin errors++; $display("FAIL ar_lost got=%b exp=0", idu_valid); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_flush_accept();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
